// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// The state encoding is fixed: IDLE=0, BUSY=1, RESP=2. Code 3 falls back to IDLE.
package mem_arb_pkg;

    localparam int   DATA_W = 32;
    localparam logic REQ_IF = 1'b0;
    localparam logic REQ_LS = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Two-way round-robin pick: with both requesting, the one not served last wins.
// Purely combinational.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic grant_valid,
    output logic grant_id
);

    always_comb begin
        grant_valid = req0 | req1;
        if (req0 && req1)
            grant_id = ~last;
        else if (req1)
            grant_id = REQ_LS;
        else
            grant_id = REQ_IF;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (0) and load/store (1).
// Every output is a register, so no input reaches an output combinationally.
//
//  state | meaning
//  IDLE  | waiting for a request; arbitrate and latch payload on grant
//  BUSY  | mem_req high, waiting for mem_ack or watchdog expiry
//  RESP  | one-cycle ack (and err on timeout) to the owner
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic [DATA_W-1:0] addr0,
    input  logic [DATA_W-1:0] addr1,
    input  logic              we0,
    input  logic              we1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic              err0,
    output logic              err1,
    output logic [DATA_W-1:0] rdata,
    output logic              sel,
    output logic              mem_req,
    output logic [DATA_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    arb_state_t        state_q, state_nx;
    logic              last_q, last_nx;
    logic              sel_nx, mem_req_nx, mem_we_nx;
    logic [DATA_W-1:0] mem_addr_nx, mem_wdata_nx, rdata_nx;
    logic              ack0_nx, ack1_nx, err0_nx, err1_nx;
    logic [CNT_W-1:0]  wd_q, wd_nx;
    logic              grant_valid, grant_id, timeout_hit;

    mem_arb_pick u_pick (
        .req0        (req0),
        .req1        (req1),
        .last        (last_q),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    assign timeout_hit = (TIMEOUT != 0) && (wd_q == WD_LAST);

    always_comb begin
        state_nx     = state_q;
        last_nx      = last_q;
        sel_nx       = sel;
        mem_req_nx   = 1'b0;
        mem_addr_nx  = mem_addr;
        mem_we_nx    = mem_we;
        mem_wdata_nx = mem_wdata;
        rdata_nx     = rdata;
        wd_nx        = wd_q;
        ack0_nx      = 1'b0;
        ack1_nx      = 1'b0;
        err0_nx      = 1'b0;
        err1_nx      = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    sel_nx       = grant_id;
                    last_nx      = grant_id;
                    mem_addr_nx  = (grant_id == REQ_LS) ? addr1  : addr0;
                    mem_we_nx    = (grant_id == REQ_LS) ? we1    : we0;
                    mem_wdata_nx = (grant_id == REQ_LS) ? wdata1 : wdata0;
                    wd_nx        = '0;
                    mem_req_nx   = 1'b1;
                    state_nx     = BUSY;
                end
            end
            BUSY: begin
                // An ack arriving in the watchdog's last cycle still counts as success.
                if (mem_ack) begin
                    rdata_nx = mem_rdata;
                    ack0_nx  = (sel == REQ_IF);
                    ack1_nx  = (sel == REQ_LS);
                    state_nx = RESP;
                end else if (timeout_hit) begin
                    rdata_nx = '0;
                    ack0_nx  = (sel == REQ_IF);
                    ack1_nx  = (sel == REQ_LS);
                    err0_nx  = (sel == REQ_IF);
                    err1_nx  = (sel == REQ_LS);
                    state_nx = RESP;
                end else begin
                    wd_nx      = wd_q + CNT_W'(1);
                    mem_req_nx = 1'b1;
                end
            end
            RESP: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            last_q    <= REQ_IF;
            sel       <= REQ_IF;
            mem_req   <= 1'b0;
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
            rdata     <= '0;
            wd_q      <= '0;
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            err0      <= 1'b0;
            err1      <= 1'b0;
        end else begin
            state_q   <= state_nx;
            last_q    <= last_nx;
            sel       <= sel_nx;
            mem_req   <= mem_req_nx;
            mem_addr  <= mem_addr_nx;
            mem_we    <= mem_we_nx;
            mem_wdata <= mem_wdata_nx;
            rdata     <= rdata_nx;
            wd_q      <= wd_nx;
            ack0      <= ack0_nx;
            ack1      <= ack1_nx;
            err0      <= err0_nx;
            err1      <= err1_nx;
        end
    end

endmodule
